// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the DMA copy engine
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        GAP_W,
        WR,
        GAP_R
    } dma_state_t;

    localparam logic [1:0] REG_SRC_LO = 2'd0;
    localparam logic [1:0] REG_DST_LO = 2'd1;
    localparam logic [1:0] REG_HI     = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // CTRL write fields
    localparam int CTRL_START_BIT  = 15;
    localparam int CTRL_IRQ_EN_BIT = 14;
    // CTRL read fields
    localparam int CTRL_BUSY_BIT   = 15;
    localparam int CTRL_DONE_BIT   = 14;

    localparam int ADDR_WIDTH = 19;

    // Replace only the byte lanes selected by bytesel.
    function automatic logic [15:0] merge_bytes(input logic [15:0] old_value,
                                                input logic [15:0] new_value,
                                                input logic [1:0]  bytesel);
        merge_bytes = old_value;
        if (bytesel[0]) merge_bytes[7:0]  = new_value[7:0];
        if (bytesel[1]) merge_bytes[15:8] = new_value[15:8];
    endfunction

endpackage

// File: rtl/dma_regs.sv
// rtl/dma_regs.sv - CPU-visible register window with ack generation
module dma_regs #(
    parameter int COUNT_WIDTH = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cs,
    input  logic                   data_m_access,
    input  logic [1:0]             data_m_addr,
    input  logic [15:0]            data_m_data_in,
    output logic [15:0]            data_m_data_out,
    input  logic                   data_m_wr_en,
    input  logic [1:0]             data_m_bytesel,
    output logic                   data_m_ack,
    input  logic                   busy,
    input  logic                   inc_src,
    input  logic                   inc_dst,
    input  logic                   dec_count,
    input  logic                   set_done,
    output logic                   start,
    output logic                   start_zero,
    output logic [18:0]            src_addr,
    output logic [18:0]            dst_addr,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   irq_en,
    output logic                   done
);
    import dma_pkg::*;

    logic        access_cycle;
    logic        wr_strobe;
    logic        rd_strobe;
    logic        ctrl_wr;
    logic [13:0] count_field;
    logic [15:0] wr_image;
    logic [15:0] rd_image;
    logic [15:0] wr_merged;

    // Decode the access, build register images and the byte-merged write value
    always_comb begin
        access_cycle = cs & data_m_access & ~data_m_ack;
        wr_strobe    = access_cycle & data_m_wr_en;
        rd_strobe    = access_cycle & ~data_m_wr_en;
        ctrl_wr      = wr_strobe & (data_m_addr == REG_CTRL);

        count_field = '0;
        count_field[COUNT_WIDTH-1:0] = count;

        case (data_m_addr)
            REG_SRC_LO: wr_image = {src_addr[14:0], 1'b0};
            REG_DST_LO: wr_image = {dst_addr[14:0], 1'b0};
            REG_HI:     wr_image = {4'b0, dst_addr[18:15], 4'b0, src_addr[18:15]};
            default:    wr_image = {1'b0, irq_en, count_field};
        endcase

        rd_image = wr_image;
        if (data_m_addr == REG_CTRL) begin
            rd_image[CTRL_BUSY_BIT] = busy;
            rd_image[CTRL_DONE_BIT] = done;
        end

        wr_merged  = merge_bytes(wr_image, data_m_data_in, data_m_bytesel);
        start      = ctrl_wr & ~busy & wr_merged[CTRL_START_BIT];
        start_zero = start & (wr_merged[COUNT_WIDTH-1:0] == '0);
    end

    // Register state, ack pulse and read data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            data_m_ack      <= 1'b0;
            data_m_data_out <= 16'h0;
            src_addr        <= '0;
            dst_addr        <= '0;
            count           <= '0;
            irq_en          <= 1'b0;
            done            <= 1'b0;
        end else begin
            data_m_ack      <= access_cycle;
            data_m_data_out <= rd_strobe ? rd_image : 16'h0;

            if (inc_src)   src_addr <= src_addr + 19'd1;
            if (inc_dst)   dst_addr <= dst_addr + 19'd1;
            if (dec_count) count    <= count - COUNT_WIDTH'(1);

            if (wr_strobe && !busy) begin
                case (data_m_addr)
                    REG_SRC_LO: src_addr[14:0] <= wr_merged[15:1];
                    REG_DST_LO: dst_addr[14:0] <= wr_merged[15:1];
                    REG_HI: begin
                        src_addr[18:15] <= wr_merged[3:0];
                        dst_addr[18:15] <= wr_merged[11:8];
                    end
                    default: begin
                        count  <= wr_merged[COUNT_WIDTH-1:0];
                        irq_en <= wr_merged[CTRL_IRQ_EN_BIT];
                    end
                endcase
            end

            // A CTRL write clears done, but a zero-count start sets it again.
            if (set_done)   done <= 1'b1;
            if (ctrl_wr)    done <= 1'b0;
            if (start_zero) done <= 1'b1;
        end
    end

endmodule

// File: rtl/dma_copy_engine.sv
// rtl/dma_copy_engine.sv - memory-to-memory word copy engine top level
module dma_copy_engine #(
    parameter int COUNT_WIDTH = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        data_m_access,
    input  logic [1:0]  data_m_addr,
    input  logic [15:0] data_m_data_in,
    output logic [15:0] data_m_data_out,
    input  logic        data_m_wr_en,
    input  logic [1:0]  data_m_bytesel,
    output logic        data_m_ack,
    output logic        m_access,
    output logic [18:0] m_addr,
    output logic        m_wr_en,
    output logic [1:0]  m_bytesel,
    output logic [15:0] m_data_out,
    input  logic [15:0] m_data_in,
    input  logic        m_ack,
    output logic        intr
);
    import dma_pkg::*;

    dma_state_t             state_q;
    dma_state_t             state_d;
    logic                   busy;
    logic                   inc_src;
    logic                   inc_dst;
    logic                   dec_count;
    logic                   set_done;
    logic                   start;
    logic                   start_zero;
    logic [18:0]            src_addr;
    logic [18:0]            dst_addr;
    logic [COUNT_WIDTH-1:0] count;
    logic                   irq_en;
    logic                   done;

    dma_regs #(
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_regs (
        .clk            (clk),
        .reset          (reset),
        .cs             (cs),
        .data_m_access  (data_m_access),
        .data_m_addr    (data_m_addr),
        .data_m_data_in (data_m_data_in),
        .data_m_data_out(data_m_data_out),
        .data_m_wr_en   (data_m_wr_en),
        .data_m_bytesel (data_m_bytesel),
        .data_m_ack     (data_m_ack),
        .busy           (busy),
        .inc_src        (inc_src),
        .inc_dst        (inc_dst),
        .dec_count      (dec_count),
        .set_done       (set_done),
        .start          (start),
        .start_zero     (start_zero),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .count          (count),
        .irq_en         (irq_en),
        .done           (done)
    );

    assign busy      = (state_q != IDLE);
    assign intr      = done & irq_en;
    assign m_bytesel = 2'b11;

    // Copy sequencer: next state and register update strobes
    always_comb begin
        state_d   = state_q;
        inc_src   = 1'b0;
        inc_dst   = 1'b0;
        dec_count = 1'b0;
        set_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !start_zero) state_d = RD;
            end
            RD: begin
                if (m_ack) begin
                    inc_src = 1'b1;
                    state_d = GAP_W;
                end
            end
            GAP_W: state_d = WR;
            WR: begin
                if (m_ack) begin
                    inc_dst   = 1'b1;
                    dec_count = 1'b1;
                    if (count == COUNT_WIDTH'(1)) begin
                        set_done = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = GAP_R;
                    end
                end
            end
            GAP_R: state_d = RD;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Registered master port, driven from the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            m_access   <= 1'b0;
            m_wr_en    <= 1'b0;
            m_addr     <= '0;
            m_data_out <= 16'h0;
        end else begin
            m_access <= (state_d == RD) || (state_d == WR);
            m_wr_en  <= (state_d == WR);
            if (state_d == RD)      m_addr <= src_addr;
            else if (state_d == WR) m_addr <= dst_addr;
            if (state_q == RD && m_ack) m_data_out <= m_data_in;
        end
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb/tb_dma_copy_engine.sv - self-checking bench for dma_copy_engine
module tb_dma_copy_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        data_m_access = 1'b0;
    logic [1:0]  data_m_addr = 2'd0;
    logic [15:0] data_m_data_in = 16'h0;
    logic [15:0] data_m_data_out;
    logic        data_m_wr_en = 1'b0;
    logic [1:0]  data_m_bytesel = 2'b00;
    logic        data_m_ack;
    logic        m_access;
    logic [18:0] m_addr;
    logic        m_wr_en;
    logic [1:0]  m_bytesel;
    logic [15:0] m_data_out;
    logic [15:0] m_data_in = 16'h0;
    logic        m_ack = 1'b0;
    logic        intr;

    always #5 clk = ~clk;

    dma_copy_engine #(.COUNT_WIDTH(14)) dut (
        .clk            (clk),
        .reset          (reset),
        .cs             (cs),
        .data_m_access  (data_m_access),
        .data_m_addr    (data_m_addr),
        .data_m_data_in (data_m_data_in),
        .data_m_data_out(data_m_data_out),
        .data_m_wr_en   (data_m_wr_en),
        .data_m_bytesel (data_m_bytesel),
        .data_m_ack     (data_m_ack),
        .m_access       (m_access),
        .m_addr         (m_addr),
        .m_wr_en        (m_wr_en),
        .m_bytesel      (m_bytesel),
        .m_data_out     (m_data_out),
        .m_data_in      (m_data_in),
        .m_ack          (m_ack),
        .intr           (intr)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: unwritten words hold a pattern derived from their address.
    logic [15:0] mem [int];
    int mem_wait = 0;

    function automatic logic [15:0] seed_word(input logic [18:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] mem_rd(input logic [18:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return seed_word(a);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            m_ack = 1'b0;
            mem_wait = 0;
        end else if (m_ack) begin
            m_ack = 1'b0;
            mem_wait = 0;
        end else if (m_access) begin
            mem_wait++;
            if (mem_wait == 2) begin
                m_ack = 1'b1;
                if (m_wr_en) mem[int'(m_addr)] = m_data_out;
                else         m_data_in = mem_rd(m_addr);
            end
        end
    end

    // Expected master transactions of the transfer in flight.
    typedef struct packed {
        logic        wr;
        logic [18:0] addr;
        logic [15:0] data;
    } xact_t;

    xact_t exp_q[$];
    bit    new_xfer = 1'b0;

    function automatic void expect_copy(input logic [18:0] s, input logic [18:0] d, input int n);
        logic [18:0] sa;
        logic [18:0] da;
        for (int i = 0; i < n; i++) begin
            sa = s + 19'(i);
            da = d + 19'(i);
            exp_q.push_back('{wr: 1'b0, addr: sa, data: 16'h0});
            exp_q.push_back('{wr: 1'b1, addr: da, data: seed_word(sa)});
        end
        new_xfer = 1'b1;
    endfunction

    // Per-cycle compare of the bus interfaces against the expected transaction stream
    logic  prev_acc = 1'b0;
    bit    cur_valid = 1'b0;
    int    idle_run = 0;
    xact_t cur;

    always @(negedge clk) begin
        if (reset) begin
            prev_acc  = 1'b0;
            cur_valid = 1'b0;
            idle_run  = 0;
        end else begin
            check("m_bytesel", m_bytesel, 2'b11);
            if (!data_m_ack) check("data_out_idle", data_m_data_out, 16'h0);
            if (m_access && !prev_acc) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_m_access", m_access, 1'b0);
                    cur_valid = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    cur_valid = 1'b1;
                    check("m_wr_en", m_wr_en, cur.wr);
                    check("m_addr", m_addr, cur.addr);
                    if (cur.wr) check("m_data_out", m_data_out, cur.data);
                    if (!new_xfer) check("idle_gap", idle_run, 1);
                    new_xfer = 1'b0;
                end
            end else if (m_access && cur_valid) begin
                check("m_addr_stable", m_addr, cur.addr);
                check("m_wr_en_stable", m_wr_en, cur.wr);
                if (cur.wr) check("m_data_stable", m_data_out, cur.data);
            end
            if (m_access) idle_run = 0;
            else          idle_run++;
            prev_acc = m_access;
        end
    end

    // One CPU access; caller is at a falling edge.
    task automatic cpu_xfer(input string nm, input logic [1:0] a, input logic we,
                            input logic [15:0] wd, input logic [1:0] bs, output logic [15:0] rd);
        int k;
        data_m_addr    = a;
        data_m_wr_en   = we;
        data_m_data_in = wd;
        data_m_bytesel = bs;
        cs             = 1'b1;
        data_m_access  = 1'b1;
        @(negedge clk);
        check({nm, "_ack_latency"}, data_m_ack, 1'b1);
        k = 0;
        while (!data_m_ack && k < 8) begin
            @(negedge clk);
            k++;
        end
        rd = data_m_data_out;
        cs            = 1'b0;
        data_m_access = 1'b0;
        data_m_wr_en  = 1'b0;
        @(negedge clk);
        check({nm, "_ack_single"}, data_m_ack, 1'b0);
    endtask

    task automatic reg_wr(input string nm, input logic [1:0] a, input logic [15:0] d, input logic [1:0] bs);
        logic [15:0] dummy;
        cpu_xfer(nm, a, 1'b1, d, bs, dummy);
    endtask

    task automatic reg_rd(input string nm, input logic [1:0] a, input logic [15:0] exp);
        logic [15:0] r;
        cpu_xfer(nm, a, 1'b0, 16'h0, 2'b11, r);
        check(nm, r, exp);
    endtask

    task automatic wait_xfer_end(input string nm);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || m_access) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_completed"}, (k < 400) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [15:0] r;
        int k;

        repeat (3) @(negedge clk);
        check("rst_m_access", m_access, 1'b0);
        check("rst_m_wr_en", m_wr_en, 1'b0);
        check("rst_m_addr", m_addr, 19'h0);
        check("rst_m_data_out", m_data_out, 16'h0);
        check("rst_m_bytesel", m_bytesel, 2'b11);
        check("rst_ack", data_m_ack, 1'b0);
        check("rst_data_out", data_m_data_out, 16'h0);
        check("rst_intr", intr, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        reg_rd("rst_src_lo", 2'd0, 16'h0000);
        reg_rd("rst_dst_lo", 2'd1, 16'h0000);
        reg_rd("rst_hi", 2'd2, 16'h0000);
        reg_rd("rst_ctrl", 2'd3, 16'h0000);

        // Register access and byte lanes
        reg_wr("wr_src_lo", 2'd0, 16'h1234, 2'b11);
        reg_wr("wr_dst_lo", 2'd1, 16'h8000, 2'b11);
        reg_wr("wr_hi", 2'd2, 16'h0201, 2'b11);
        reg_rd("rd_src_lo", 2'd0, 16'h1234);
        reg_rd("rd_dst_lo", 2'd1, 16'h8000);
        reg_rd("rd_hi", 2'd2, 16'h0201);
        reg_wr("wr_src_hibyte", 2'd0, 16'hAB00, 2'b10);
        reg_rd("rd_src_bytelane", 2'd0, 16'hAB34);

        // Three-word copy 0x10000 -> 0x20000 (byte addresses)
        reg_wr("cp_src_lo", 2'd0, 16'h0000, 2'b11);
        reg_wr("cp_dst_lo", 2'd1, 16'h0000, 2'b11);
        reg_wr("cp_hi", 2'd2, 16'h0201, 2'b11);
        expect_copy(19'h08000, 19'h10000, 3);
        reg_wr("cp_ctrl", 2'd3, 16'hC003, 2'b11);
        wait_xfer_end("cp");
        check("cp_intr", intr, 1'b1);
        check("cp_mem0", mem_rd(19'h10000), 16'h25C3);
        check("cp_mem1", mem_rd(19'h10001), 16'h25C2);
        check("cp_mem2", mem_rd(19'h10002), 16'h25C1);
        reg_rd("cp_rd_ctrl", 2'd3, 16'h4000);
        reg_rd("cp_rd_src_lo", 2'd0, 16'h0006);
        reg_rd("cp_rd_dst_lo", 2'd1, 16'h0006);
        reg_rd("cp_rd_hi", 2'd2, 16'h0201);
        reg_wr("cp_clear", 2'd3, 16'h0000, 2'b11);
        check("cp_intr_cleared", intr, 1'b0);
        reg_rd("cp_rd_ctrl_cleared", 2'd3, 16'h0000);

        // Zero count: done without any bus cycle; a second zero start keeps done set
        reg_wr("z_ctrl", 2'd3, 16'hC000, 2'b11);
        check("z_intr", intr, 1'b1);
        repeat (10) @(negedge clk);
        reg_rd("z_rd_ctrl", 2'd3, 16'h4000);
        check("z_intr_held", intr, 1'b1);
        reg_wr("z_ctrl_again", 2'd3, 16'hC000, 2'b11);
        check("z_intr_restart", intr, 1'b1);
        reg_wr("z_clear", 2'd3, 16'h0000, 2'b11);
        check("z_intr_cleared", intr, 1'b0);

        // Address wrap at the top of the 19-bit word space
        reg_wr("w_src_lo", 2'd0, 16'hFFFE, 2'b11);
        reg_wr("w_dst_lo", 2'd1, 16'h4000, 2'b11);
        reg_wr("w_hi", 2'd2, 16'h000F, 2'b11);
        expect_copy(19'h7FFFF, 19'h02000, 2);
        reg_wr("w_ctrl", 2'd3, 16'h8002, 2'b11);
        wait_xfer_end("w");
        check("w_intr_disabled", intr, 1'b0);
        check("w_mem0", mem_rd(19'h02000), 16'h5A3C);
        check("w_mem1", mem_rd(19'h02001), 16'hA5C3);
        reg_rd("w_rd_ctrl", 2'd3, 16'h4000);
        reg_rd("w_rd_src_lo", 2'd0, 16'h0002);
        reg_rd("w_rd_hi", 2'd2, 16'h0000);

        // Writes while busy are acked but ignored
        reg_wr("b_src_lo", 2'd0, 16'h1000, 2'b11);
        reg_wr("b_dst_lo", 2'd1, 16'h3000, 2'b11);
        reg_wr("b_hi", 2'd2, 16'h0000, 2'b11);
        expect_copy(19'h00800, 19'h01800, 4);
        reg_wr("b_ctrl", 2'd3, 16'h8004, 2'b11);
        reg_wr("b_wr_busy", 2'd0, 16'h5555, 2'b11);
        cpu_xfer("b_rd_ctrl", 2'd3, 1'b0, 16'h0, 2'b11, r);
        check("b_busy_bit", r[15], 1'b1);
        wait_xfer_end("b");
        reg_rd("b_rd_src_lo", 2'd0, 16'h1008);
        reg_rd("b_rd_dst_lo", 2'd1, 16'h3008);
        reg_rd("b_rd_ctrl_end", 2'd3, 16'h4000);

        // Reset while a write cycle is on the master port
        reg_wr("r_src_lo", 2'd0, 16'h2000, 2'b11);
        reg_wr("r_dst_lo", 2'd1, 16'h6000, 2'b11);
        expect_copy(19'h01000, 19'h03000, 4);
        reg_wr("r_ctrl", 2'd3, 16'hC004, 2'b11);
        k = 0;
        while (!(m_access && m_wr_en) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("r_reached_wr", m_access & m_wr_en, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("r_m_access", m_access, 1'b0);
        check("r_m_wr_en", m_wr_en, 1'b0);
        check("r_intr", intr, 1'b0);
        exp_q.delete();
        reset = 1'b0;
        @(negedge clk);
        reg_rd("r_rd_src_lo", 2'd0, 16'h0000);
        reg_rd("r_rd_dst_lo", 2'd1, 16'h0000);
        reg_rd("r_rd_hi", 2'd2, 16'h0000);
        reg_rd("r_rd_ctrl", 2'd3, 16'h0000);
        repeat (10) @(negedge clk);
        check("r_no_access", m_access, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- Memory-to-memory DMA copy engine for the s80x86 SoC.
- Responder on the CPU I/O data bus: a 4-register window, decoded by the top level into its `cs`.
- Initiator on a second memory-bus master port, presented to the memory arbiter in the same way as the CPU data bus.
- Copies N 16-bit words from a source to a destination, then raises a level interrupt for the PIC.

Parameters:
- COUNT_WIDTH, 14, width of the word-count register (max 16383 words per transfer).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cs  in  1  register window select from top-level I/O decode
- data_m_access  in  1  CPU I/O access request
- data_m_addr  in  2  CPU word address bits [2:1]; selects register
- data_m_data_in  in  16  CPU write data
- data_m_data_out  out  16  read data; zero unless acking a read
- data_m_wr_en  in  1  CPU write strobe
- data_m_bytesel  in  2  byte lanes; [0]=low, [1]=high
- data_m_ack  out  1  one-cycle completion pulse
- m_access  out  1  master request
- m_addr  out  19  master word address [19:1]
- m_wr_en  out  1  master write
- m_bytesel  out  2  always 2'b11
- m_data_out  out  16  master write data
- m_data_in  in  16  master read data, valid with m_ack
- m_ack  in  1  master completion pulse
- intr  out  1  level interrupt request

Behaviour:
- Reset values, next edge after reset asserted:
  - all outputs 0 (m_bytesel=2'b11);
  - SRC, DST, COUNT, irq_en, done all cleared;
  - FSM to IDLE.
  - Reset mid-transfer: m_access drops on that edge, and the transfer is abandoned silently.
- Slave handshake:
  - data_m_ack <= cs & data_m_access & ~data_m_ack, giving 1-cycle latency.
  - Exactly one ack per access; the CPU holds the request until ack.
  - Register write and read capture happen on the cycle ack is asserted.
  - data_m_data_out is driven only during ack, else 0, as required by the OR-combined bus.
- Register map (addr[2:1]):
  - 0 SRC_LO: source byte address [15:1]; bit0 reads 0.
  - 1 DST_LO: destination byte address [15:1]; bit0 reads 0.
  - 2 HI: [3:0] = src[19:16], [11:8] = dst[19:16]; other bits read 0.
  - 3 CTRL, write: [13:0] count, [14] irq_en, [15] start. Any CTRL write clears done.
  - 3 CTRL, read: [15] busy, [14] done, [13:0] remaining count.
- Byte-lane writes honour bytesel.
- While busy, writes to registers 0–3 are acked but ignored, except that a CTRL write still clears done. Reads are always live.
- FSM states:
  - IDLE: CTRL write with start=1 latches count and irq_en. If count==0, go to IDLE, set done, and issue no bus cycle; otherwise go to RD.
  - RD: m_access=1, m_wr_en=0, m_addr=SRC. On m_ack, latch m_data_in into m_data_out, increment SRC, and go to GAP_W.
  - GAP_W: m_access=0 for exactly one cycle, then WR.
  - WR: m_access=1, m_wr_en=1, m_addr=DST. On m_ack, increment DST and decrement count. If count becomes 0, go to IDLE and set done; else go to GAP_R.
  - GAP_R: one idle cycle, then RD.
- Master outputs are registered. m_access deasserts on the edge following m_ack, and m_addr, m_wr_en and m_data_out are stable while m_access is high.
- Addresses are 19-bit word addresses and increment modulo 2^19, so 0xFFFFE wraps to 0x00000.
- busy = (state != IDLE). Registers reflect live incrementing values during a transfer.
- intr = done & irq_en, held as a level until a CTRL write clears done.
- If done is set and a CTRL write clears it on the same cycle, the clear wins unless that write also starts a zero-count transfer; in that case done=1.

Decomposition:
- Package dma_pkg:
  - state enum {IDLE, RD, GAP_W, WR, GAP_R};
  - register index constants REG_SRC_LO=0, REG_DST_LO=1, REG_HI=2, REG_CTRL=3;
  - CTRL bit positions.
- One natural sub-module, dma_regs: the slave register file with its ack generation and byte-lane write logic. It exports a start pulse and the latched SRC/DST/count/irq_en, and accepts update strobes from the FSM.

Test Plan:
- Register access:
  - Stimulus: write SRC_LO=0x1234, DST_LO=0x8000, HI=0x0201 with bytesel=11, then read each.
  - Required: reads return 0x1234, 0x8000, 0x0201, each ack exactly one cycle after the request.
  - Stimulus: byte write 0xAB to SRC_LO with bytesel=10.
  - Required: SRC_LO reads 0xAB34.
- Three-word copy:
  - Stimulus: src 0x10000, dst 0x20000, CTRL=0xC003; memory model acks after 2 cycles.
  - Required: master sequence RD 0x08000, WR 0x10000, RD 0x08001, WR 0x10001, RD 0x08002, WR 0x10002 (word addresses), with data copied.
  - Required: exactly one idle cycle between requests, then done=1 and intr=1.
  - Stimulus: CTRL write 0x0000.
  - Required: intr=0.
- Zero count:
  - Stimulus: CTRL=0xC000.
  - Required: no m_access ever; next read of CTRL = 0x4000; intr=1.
- Wrap-around:
  - Stimulus: src 0xFFFFE, count 2.
  - Required: reads at word addresses 0x7FFFF then 0x00000.
- Busy behaviour and reset:
  - Stimulus: during a transfer, write SRC_LO=0x5555.
  - Required: ack is given; SRC unchanged; CTRL bit15=1.
  - Stimulus: assert reset while in WR with m_access high.
  - Required: m_access=0, intr=0, and all registers read 0 after reset.
